mem_access_stage: RTL and testbench

- Fourth stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register and performs data-memory access through a variable-latency req/ready handshake.
- Resolves taken branches back to fetch (PCSrc_M, PCBranch_M) and stalls upstream stages while a memory access is outstanding.
- Feeds the registered MEM/WB bundle to write-back.

---
 rtl/mem_access_stage_pkg.sv | 17 +
 rtl/mem_access_stage_handshake_fsm.sv | 41 ++++
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 tb/tb_mem_access_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: handshake state encodings, default widths
// and the mem-op decode, so hazard logic can decode Stall_M the same way.
package mem_access_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MEMWAIT = 1'b1;

  // A store wins when both control bits are set; either bit makes it a mem op.
  function automatic logic is_mem_op(input logic valid, input logic mem_we, input logic mem_rd);
    return valid & (mem_we | mem_rd);
  endfunction

endpackage

// File: rtl/mem_access_stage_handshake_fsm.sv
// Data-memory handshake controller (module mem_handshake_fsm): owns the RUN/MEMWAIT
// state, the request, the upstream stall and the completion strobe for the M slot.
module mem_handshake_fsm
  import mem_access_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic capture_mem,
  input  logic valid_m,
  input  logic mem_ready,
  output logic mem_req,
  output logic stall,
  output logic complete
);

  logic state;
  logic next_state;

  assign mem_req  = (state == ST_MEMWAIT);
  assign stall    = mem_req & ~mem_ready;
  assign complete = valid_m & (~mem_req | mem_ready);

  // While stalled M holds its op; otherwise the state follows what M captures next.
  always_comb begin
    next_state = ST_RUN;
    if (stall) begin
      next_state = ST_MEMWAIT;
    end else if (capture_mem) begin
      next_state = ST_MEMWAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: EX/MEM register, variable-latency data-memory access, branch
// resolution and MEM/WB register. Optional alignment check: MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_AW = REG_AW_DEF
)(
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Valid_E,
  input  logic              RegWriteEN_E,
  input  logic              Mem2RegSEL_E,
  input  logic              MemWriteEN_E,
  input  logic              Branch_E,
  input  logic              Zero_E,
  input  logic [DATA_W-1:0] ALUOut_E,
  input  logic [DATA_W-1:0] WriteData_E,
  input  logic [REG_AW-1:0] RegAddr3_E,
  input  logic [ADDR_W-1:0] PCBranch_E,
  output logic              Stall_M,
  output logic              PCSrc_M,
  output logic [ADDR_W-1:0] PCBranch_M,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemReady,
  output logic              Valid_W,
  output logic              RegWriteEN_W,
  output logic [REG_AW-1:0] RegAddr3_W,
  output logic [DATA_W-1:0] Result_W,
  output logic              AlignFault_M
);

  logic              valid_m;
  logic              regwrite_m;
  logic              mem2reg_m;
  logic              memwrite_m;
  logic              branch_m;
  logic              zero_m;
  logic [DATA_W-1:0] aluout_m;
  logic [DATA_W-1:0] wdata_m;
  logic [REG_AW-1:0] rd_m;
  logic [ADDR_W-1:0] pcbranch_m;

  logic mem_req;
  logic stall;
  logic complete;
  logic capture_mem;
  logic fault_m;
  logic load_m;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_fault;

  // Misaligned ops bypass the memory entirely and complete in RUN as a faulted no-write.
  assign capture_mem = is_mem_op(Valid_E, MemWriteEN_E, Mem2RegSEL_E) & ~(|ALUOut_E[1:0]);
  assign fault_m     = is_mem_op(valid_m, memwrite_m, mem2reg_m) & (|aluout_m[1:0]);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      align_fault <= 1'b0;
    end else if (fault_m) begin
      align_fault <= 1'b1;
    end
  end

  assign AlignFault_M = align_fault;
`else
  assign capture_mem  = is_mem_op(Valid_E, MemWriteEN_E, Mem2RegSEL_E);
  assign fault_m      = 1'b0;
  assign AlignFault_M = 1'b0;
`endif

  mem_handshake_fsm u_fsm (
    .clk         (CLOCK),
    .reset       (RESET),
    .capture_mem (capture_mem),
    .valid_m     (valid_m),
    .mem_ready   (MemReady),
    .mem_req     (mem_req),
    .stall       (stall),
    .complete    (complete)
  );

  // EX/MEM register freezes while the memory access is outstanding.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      valid_m    <= 1'b0;
      regwrite_m <= 1'b0;
      mem2reg_m  <= 1'b0;
      memwrite_m <= 1'b0;
      branch_m   <= 1'b0;
      zero_m     <= 1'b0;
      aluout_m   <= '0;
      wdata_m    <= '0;
      rd_m       <= '0;
      pcbranch_m <= '0;
    end else if (!stall) begin
      valid_m    <= Valid_E;
      regwrite_m <= RegWriteEN_E;
      mem2reg_m  <= Mem2RegSEL_E;
      memwrite_m <= MemWriteEN_E;
      branch_m   <= Branch_E;
      zero_m     <= Zero_E;
      aluout_m   <= ALUOut_E;
      wdata_m    <= WriteData_E;
      rd_m       <= RegAddr3_E;
      pcbranch_m <= PCBranch_E;
    end
  end

  assign load_m     = mem2reg_m & ~memwrite_m & ~fault_m;
  assign Stall_M    = stall;
  assign MemReq     = mem_req;
  assign MemWE      = mem_req & memwrite_m;
  assign MemAddr    = ADDR_W'(aluout_m);
  assign MemWData   = wdata_m;
  assign PCSrc_M    = valid_m & branch_m & zero_m;
  assign PCBranch_M = pcbranch_m;

  // Non-completing cycles send a bubble to W but leave its data fields untouched.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      Valid_W      <= 1'b0;
      RegWriteEN_W <= 1'b0;
      RegAddr3_W   <= '0;
      Result_W     <= '0;
    end else begin
      Valid_W      <= complete;
      RegWriteEN_W <= complete & regwrite_m & ~fault_m;
      if (complete) begin
        RegAddr3_W <= rd_m;
        Result_W   <= load_m ? MemRData : aluout_m;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected W
// results; a negedge monitor pops and compares whenever Valid_W is seen.
module tb_mem_access_stage;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Valid_E, RegWriteEN_E, Mem2RegSEL_E, MemWriteEN_E, Branch_E, Zero_E;
  logic [31:0] ALUOut_E, WriteData_E, PCBranch_E;
  logic [4:0]  RegAddr3_E;
  logic        Stall_M, PCSrc_M, MemReq, MemWE, MemReady;
  logic [31:0] PCBranch_M, MemAddr, MemWData, MemRData;
  logic        Valid_W, RegWriteEN_W, AlignFault_M;
  logic [4:0]  RegAddr3_W;
  logic [31:0] Result_W;

  mem_access_stage dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .Valid_E      (Valid_E),
    .RegWriteEN_E (RegWriteEN_E),
    .Mem2RegSEL_E (Mem2RegSEL_E),
    .MemWriteEN_E (MemWriteEN_E),
    .Branch_E     (Branch_E),
    .Zero_E       (Zero_E),
    .ALUOut_E     (ALUOut_E),
    .WriteData_E  (WriteData_E),
    .RegAddr3_E   (RegAddr3_E),
    .PCBranch_E   (PCBranch_E),
    .Stall_M      (Stall_M),
    .PCSrc_M      (PCSrc_M),
    .PCBranch_M   (PCBranch_M),
    .MemReq       (MemReq),
    .MemWE        (MemWE),
    .MemAddr      (MemAddr),
    .MemWData     (MemWData),
    .MemRData     (MemRData),
    .MemReady     (MemReady),
    .Valid_W      (Valid_W),
    .RegWriteEN_W (RegWriteEN_W),
    .RegAddr3_W   (RegAddr3_W),
    .Result_W     (Result_W),
    .AlignFault_M (AlignFault_M)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] result;
    int          lat;
    int          issueCyc;
  } wbExp_t;

  wbExp_t      sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          memLat = 0;
  int          waitCnt = 0;
  int          reqCnt = 0;
  int          stallCnt = 0;
  int          pcsrcCnt = 0;
  logic [31:0] expAddr = '0;
  logic [31:0] expWData = '0;
  logic        expWe = 1'b0;
  logic [31:0] expPcb = '0;
  logic [31:0] dmem [0:255];

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Memory model: ready after memLat extra request cycles, contents reloaded on reset.
  always @(posedge CLOCK) begin
    if (RESET || !MemReq || MemReady) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
    if (RESET) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
      dmem[64] <= 32'hDEADBEEF;
      dmem[65] <= 32'h11111111;
      dmem[66] <= 32'h22222222;
      dmem[67] <= 32'h33333333;
      dmem[68] <= 32'h44444444;
    end else if (MemReq && MemReady && MemWE) begin
      dmem[MemAddr[9:2]] <= MemWData;
    end
  end

  assign MemReady = MemReq && (waitCnt >= memLat);
  assign MemRData = dmem[MemAddr[9:2]];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: request bus, stall and branch counters, and the W scoreboard.
  always @(negedge CLOCK) begin
    if (!RESET) begin
      if (MemReq) begin
        reqCnt++;
        checkOutput("mem_req_bus", {MemWE, MemAddr, MemWData}, {expWe, expAddr, expWData});
      end
      if (Stall_M) stallCnt++;
      if (PCSrc_M) begin
        pcsrcCnt++;
        checkOutput("branch_target", PCBranch_M, expPcb);
      end
      if (Valid_W) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_wb", {RegAddr3_W, Result_W}, 128'hFFFF_FFFF_FFFF);
        end else begin
          wbExp_t e;
          e = sb.pop_front();
          checkOutput("wb_bundle", {RegWriteEN_W, RegAddr3_W, Result_W}, {e.rw, e.rd, e.result});
          checkOutput("wb_latency", cyc - e.issueCyc, e.lat);
        end
      end
    end
  end

  // Drives one EX instruction, holds it while stalled, and records its expected W result.
  task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic mw,
                               input logic br, input logic z, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pcb,
                               input logic push, input logic expRw, input logic [31:0] expResult,
                               input int lat);
    int budget;
    wbExp_t e;
    Valid_E = v; RegWriteEN_E = rw; Mem2RegSEL_E = m2r; MemWriteEN_E = mw;
    Branch_E = br; Zero_E = z; ALUOut_E = alu; WriteData_E = wd;
    RegAddr3_E = rd; PCBranch_E = pcb;
    budget = 0;
    forever begin
      @(negedge CLOCK);
      if (!Stall_M) break;
      budget++;
      if (budget > 50) begin
        checks++;
        failures++;
        $display("[TB] FAIL stall_timeout actual=%0d required<=50", budget);
        break;
      end
      @(posedge CLOCK);
      #1;
    end
    @(posedge CLOCK);
    #1;
    if (v && (mw || m2r)) begin
      expAddr = alu; expWe = mw; expWData = wd;
    end
    if (push) begin
      e.rw = expRw; e.rd = rd; e.result = expResult; e.lat = lat; e.issueCyc = cyc;
      sb.push_back(e);
    end
    Valid_E = 1'b0; RegWriteEN_E = 1'b0; Mem2RegSEL_E = 1'b0; MemWriteEN_E = 1'b0;
    Branch_E = 1'b0; Zero_E = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic clearCounters();
    reqCnt = 0; stallCnt = 0; pcsrcCnt = 0;
  endtask

  initial begin
    RESET = 1'b1;
    Valid_E = 1'b0; RegWriteEN_E = 1'b0; Mem2RegSEL_E = 1'b0; MemWriteEN_E = 1'b0;
    Branch_E = 1'b0; Zero_E = 1'b0; ALUOut_E = '0; WriteData_E = '0;
    RegAddr3_E = '0; PCBranch_E = '0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    checkOutput("reset_mem_bus", {MemReq, MemWE, MemAddr, MemWData}, 128'h0);
    checkOutput("reset_wb_ctrl", {Stall_M, PCSrc_M, PCBranch_M, Valid_W, RegWriteEN_W,
                                  RegAddr3_W, Result_W, AlignFault_M}, 128'h0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    idleCycles(1);

    // ALU op straight through
    clearCounters();
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h10, 32'h0, 5'd8, 32'h0, 1, 1, 32'h10, 1);
    idleCycles(3);
    checkOutput("add_no_req", reqCnt, 0);

    // Load with ready on the third request cycle
    clearCounters();
    memLat = 2;
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h100, 32'h0, 5'd9, 32'h0, 1, 1, 32'hDEADBEEF, 3);
    idleCycles(6);
    checkOutput("slow_load_req_cycles", reqCnt, 3);
    checkOutput("slow_load_stall_cycles", stallCnt, 2);

    // Zero-wait store, then read it back
    clearCounters();
    memLat = 0;
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h40, 32'h1234, 5'd0, 32'h0, 1, 0, 32'h40, 1);
    idleCycles(3);
    checkOutput("store_req_cycles", reqCnt, 1);
    checkOutput("store_stall_cycles", stallCnt, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h40, 32'h0, 5'd3, 32'h0, 1, 1, 32'h1234, 1);
    idleCycles(3);

    // Four back-to-back zero-wait loads
    clearCounters();
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h104, 32'h0, 5'd10, 32'h0, 1, 1, 32'h11111111, 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h108, 32'h0, 5'd11, 32'h0, 1, 1, 32'h22222222, 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h10C, 32'h0, 5'd12, 32'h0, 1, 1, 32'h33333333, 1);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h110, 32'h0, 5'd13, 32'h0, 1, 1, 32'h44444444, 1);
    idleCycles(3);
    checkOutput("b2b_stall_cycles", stallCnt, 0);
    checkOutput("b2b_req_cycles", reqCnt, 4);

    // Taken and not-taken branches
    clearCounters();
    expPcb = 32'h200;
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h200, 1, 0, 32'h0, 1);
    idleCycles(3);
    checkOutput("taken_branch_pulses", pcsrcCnt, 1);
    clearCounters();
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h5, 32'h0, 5'd0, 32'h300, 1, 0, 32'h5, 1);
    idleCycles(3);
    checkOutput("untaken_branch_pulses", pcsrcCnt, 0);

    // Misaligned load
    clearCounters();
`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h102, 32'h0, 5'd7, 32'h0, 1, 0, 32'h102, 1);
    idleCycles(3);
    checkOutput("misaligned_req_cycles", reqCnt, 0);
    checkOutput("align_fault_set", AlignFault_M, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h20, 32'h0, 5'd4, 32'h0, 1, 1, 32'h20, 1);
    idleCycles(3);
    checkOutput("align_fault_sticky", AlignFault_M, 1);
`else
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h102, 32'h0, 5'd7, 32'h0, 1, 1, 32'hDEADBEEF, 1);
    idleCycles(3);
    checkOutput("misaligned_req_cycles", reqCnt, 1);
    checkOutput("align_fault_tied_low", AlignFault_M, 0);
`endif

    checkOutput("sb_drain", sb.size(), 0);

    // Reset in the second MEMWAIT cycle abandons the request
    memLat = 10;
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h104, 32'h0, 5'd14, 32'h0, 0, 0, 32'h0, 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    @(negedge CLOCK);
    checkOutput("reset_in_wait", {MemReq, Stall_M, Valid_W, AlignFault_M}, 4'b0000);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    memLat = 0;
    idleCycles(4);
    checkOutput("sb_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
